// File: rtl/apb_pkg.sv
// Shared types for the APB master: FSM state encoding, default widths, request payload.
package apb_pkg;

  localparam int unsigned APB_ADDR_W  = 5;
  localparam int unsigned APB_DATA_W  = 32;
  localparam int unsigned APB_STRB_W  = APB_DATA_W / 8;
  localparam int unsigned APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic                  prot;
  } apb_req_t;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase stall counter; 'expired' marks the TIMEOUT-th consecutive stalled cycle.
module apb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // expired is set one cycle early so the master sees it during the final stalled cycle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (count) begin
      cnt     <= cnt + CNT_W'(1);
      expired <= (cnt == CNT_W'(TIMEOUT - 2));
    end
  end

endmodule

// File: rtl/apb_master.sv
// Valid/ready command port to APB master bridge, one transfer outstanding.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  input  logic                req_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrobe,
  output logic                Prot,
  input  logic                pready,
  input  logic                pslverr,
  input  logic [DATA_W-1:0]   prdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  apb_state_e state, state_next;
  apb_req_t   req_in;
  logic       accept;
  logic       complete;
  logic       abort;
  logic       wd_expired;

`ifdef APB_MASTER_TIMEOUT_EN
  logic wd_clear;
  logic wd_count;

  assign wd_clear = accept;
  assign wd_count = (state == ACCESS) && !pready;

  apb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_expired)
  );
`else
  // No watchdog: never expires (TIMEOUT >= 2, so this is constant 0).
  assign wd_expired = (TIMEOUT == 0);
`endif

  // Bundle the incoming request into the shared payload type.
  always_comb begin
    req_in       = '0;
    req_in.write = req_write;
    req_in.addr  = APB_ADDR_W'(req_addr);
    req_in.wdata = APB_DATA_W'(req_wdata);
    req_in.strb  = APB_STRB_W'(req_strb);
    req_in.prot  = req_prot;
  end

  // Next-state and transfer-event decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (wd_expired) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake and APB control flags are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      psel      <= (state_next == SETUP) || (state_next == ACCESS);
      penable   <= (state_next == ACCESS);
    end
  end

  // Payload loads only on acceptance and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwrite  <= 1'b0;
      addr    <= '0;
      pwdata  <= '0;
      pstrobe <= '0;
      Prot    <= 1'b0;
    end else if (accept) begin
      pwrite  <= req_in.write;
      addr    <= ADDR_W'(req_in.addr);
      pwdata  <= DATA_W'(req_in.wdata);
      pstrobe <= req_in.write ? STRB_W'(req_in.strb) : '0;
      Prot    <= req_in.prot;
    end
  end

  // Response capture: slave result on completion, forced error on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (complete) begin
      rsp_rdata <= pwrite ? '0 : prdata;
      rsp_err   <= pslverr;
    end else if (abort) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; the timeout steps follow APB_MASTER_TIMEOUT_EN.
module tb_apb_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        req_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  addr;
  logic [31:0] pwdata;
  logic [3:0]  pstrobe;
  logic        Prot;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .ADDR_W  (5),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .addr      (addr),
    .pwdata    (pwdata),
    .pstrobe   (pstrobe),
    .Prot      (Prot),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs_zero(input string tag);
    chk({tag, ".psel"},      32'(psel),      32'h0);
    chk({tag, ".penable"},   32'(penable),   32'h0);
    chk({tag, ".pwrite"},    32'(pwrite),    32'h0);
    chk({tag, ".addr"},      32'(addr),      32'h0);
    chk({tag, ".pwdata"},    pwdata,         32'h0);
    chk({tag, ".pstrobe"},   32'(pstrobe),   32'h0);
    chk({tag, ".prot"},      32'(Prot),      32'h0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, ".rsp_rdata"}, rsp_rdata,      32'h0);
    chk({tag, ".rsp_err"},   32'(rsp_err),   32'h0);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'h0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = 1'b0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    prdata = '0;
    step(); step();
    chk_idle_outputs_zero("reset");
    reset = 1'b0;
    step();
    chk("post_reset.req_ready", 32'(req_ready), 32'h1);

    // Zero-wait write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h03; req_wdata = 32'hDEAD_BEEF;
    req_strb = 4'hF; pready = 1'b1;
    step();
    chk("wr.setup.psel",    32'(psel),      32'h1);
    chk("wr.setup.penable", 32'(penable),   32'h0);
    chk("wr.setup.pwrite",  32'(pwrite),    32'h1);
    chk("wr.setup.addr",    32'(addr),      32'h3);
    chk("wr.setup.pwdata",  pwdata,         32'hDEAD_BEEF);
    chk("wr.setup.pstrobe", 32'(pstrobe),   32'hF);
    chk("wr.setup.rready",  32'(req_ready), 32'h0);
    req_valid = 1'b0;
    step();
    chk("wr.access.psel",    32'(psel),      32'h1);
    chk("wr.access.penable", 32'(penable),   32'h1);
    chk("wr.access.rvalid",  32'(rsp_valid), 32'h0);
    step();
    chk("wr.resp.rvalid",  32'(rsp_valid), 32'h1);
    chk("wr.resp.err",     32'(rsp_err),   32'h0);
    chk("wr.resp.rdata",   rsp_rdata,      32'h0);
    chk("wr.resp.psel",    32'(psel),      32'h0);
    chk("wr.resp.penable", 32'(penable),   32'h0);
    rsp_ready = 1'b1;
    step();
    chk("wr.done.rvalid", 32'(rsp_valid), 32'h0);
    chk("wr.done.rready", 32'(req_ready), 32'h1);
    chk("wr.done.pwdata", pwdata,         32'hDEAD_BEEF);
    rsp_ready = 1'b0;

    // Read with two wait states and a pslverr pulse while pready is low
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h03; req_strb = 4'hF; pready = 1'b0;
    step();
    chk("rd.setup.pwrite",  32'(pwrite),  32'h0);
    chk("rd.setup.pstrobe", 32'(pstrobe), 32'h0);
    chk("rd.setup.addr",    32'(addr),    32'h3);
    chk("rd.setup.penable", 32'(penable), 32'h0);
    req_valid = 1'b0; pslverr = 1'b1; prdata = 32'h1234_5678;
    step();
    chk("rd.wait1.penable", 32'(penable),   32'h1);
    chk("rd.wait1.rvalid",  32'(rsp_valid), 32'h0);
    pslverr = 1'b0;
    step();
    chk("rd.wait2.penable", 32'(penable),   32'h1);
    chk("rd.wait2.addr",    32'(addr),      32'h3);
    pready = 1'b1; prdata = 32'hDEAD_BEEF;
    step();
    chk("rd.resp.rvalid", 32'(rsp_valid), 32'h1);
    chk("rd.resp.rdata",  rsp_rdata,      32'hDEAD_BEEF);
    chk("rd.resp.err",    32'(rsp_err),   32'h0);
    chk("rd.resp.psel",   32'(psel),      32'h0);

    // Response back-pressure with a pending new request
    pready = 1'b0; prdata = 32'h0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h07; req_wdata = 32'h0000_1111;
    req_strb = 4'h3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.rvalid", 32'(rsp_valid), 32'h1);
      chk("bp.rdata",  rsp_rdata,      32'hDEAD_BEEF);
      chk("bp.rready", 32'(req_ready), 32'h0);
      chk("bp.addr",   32'(addr),      32'h3);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp.idle.rvalid", 32'(rsp_valid), 32'h0);
    chk("bp.idle.rready", 32'(req_ready), 32'h1);
    chk("bp.idle.psel",   32'(psel),      32'h0);
    chk("bp.idle.addr",   32'(addr),      32'h3);
    rsp_ready = 1'b0;
    step();
    chk("wr2.setup.addr",    32'(addr),    32'h7);
    chk("wr2.setup.pwrite",  32'(pwrite),  32'h1);
    chk("wr2.setup.pwdata",  pwdata,       32'h0000_1111);
    chk("wr2.setup.pstrobe", 32'(pstrobe), 32'h3);
    req_valid = 1'b0; pready = 1'b1; pslverr = 1'b1;
    step();
    chk("wr2.access.penable", 32'(penable), 32'h1);
    step();
    chk("wr2.resp.rvalid", 32'(rsp_valid), 32'h1);
    chk("wr2.resp.err",    32'(rsp_err),   32'h1);
    chk("wr2.resp.rdata",  rsp_rdata,      32'h0);
    pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b1;
    step();
    chk("wr2.done.rready", 32'(req_ready), 32'h1);
    rsp_ready = 1'b0;

    // Reset in the middle of ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h09; req_prot = 1'b1;
    step();
    chk("rst.setup.prot", 32'(Prot), 32'h1);
    chk("rst.setup.addr", 32'(addr), 32'h9);
    req_valid = 1'b0;
    step();
    chk("rst.access.penable", 32'(penable), 32'h1);
    reset = 1'b1;
    step();
    chk_idle_outputs_zero("rst.mid");
    reset = 1'b0; pready = 1'b1;
    step();
    chk("rst.after.rready", 32'(req_ready), 32'h1);
    chk("rst.after.rvalid", 32'(rsp_valid), 32'h0);
    step();
    chk("rst.noresp.rvalid", 32'(rsp_valid), 32'h0);
    chk("rst.noresp.psel",   32'(psel),      32'h0);
    pready = 1'b0; req_prot = 1'b0;

    // pready on the fourth stalled cycle completes normally in both builds
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h04; prdata = 32'h0000_AA55;
    step();
    req_valid = 1'b0;
    step(); step(); step(); step();
    chk("late.a4.penable", 32'(penable),   32'h1);
    chk("late.a4.rvalid",  32'(rsp_valid), 32'h0);
    pready = 1'b1;
    step();
    chk("late.resp.rvalid", 32'(rsp_valid), 32'h1);
    chk("late.resp.rdata",  rsp_rdata,      32'h0000_AA55);
    chk("late.resp.err",    32'(rsp_err),   32'h0);
    pready = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // pready stuck low
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h05; prdata = 32'h0000_9999;
    step();
    req_valid = 1'b0;
    step(); step(); step(); step();
    chk("stuck.a4.penable", 32'(penable), 32'h1);
    step();
`ifdef APB_MASTER_TIMEOUT_EN
    chk("to.resp.rvalid",  32'(rsp_valid), 32'h1);
    chk("to.resp.err",     32'(rsp_err),   32'h1);
    chk("to.resp.rdata",   rsp_rdata,      32'h0);
    chk("to.resp.psel",    32'(psel),      32'h0);
    chk("to.resp.penable", 32'(penable),   32'h0);
`else
    chk("stuck.a5.penable", 32'(penable),   32'h1);
    chk("stuck.a5.rvalid",  32'(rsp_valid), 32'h0);
    for (int i = 0; i < 20; i++) step();
    chk("stuck.long.penable", 32'(penable), 32'h1);
    pready = 1'b1; prdata = 32'h0000_1357;
    step();
    chk("stuck.resp.rvalid", 32'(rsp_valid), 32'h1);
    chk("stuck.resp.rdata",  rsp_rdata,      32'h0000_1357);
    chk("stuck.resp.err",    32'(rsp_err),   32'h0);
    pready = 1'b0;
`endif
    rsp_ready = 1'b1;
    step();
    chk("final.rready", 32'(req_ready), 32'h1);
    chk("final.rvalid", 32'(rsp_valid), 32'h0);
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
